// File: rtl/result_monitor_if.sv
// ============================================================================
// Module   : result_monitor_if
// Purpose  : sel/result link from the dice/traffic-light multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_monitor_if;
    logic       sel;
    logic [2:0] result;

    modport master (output sel, output result);
    modport slave  (input  sel, input  result);
endinterface

`default_nettype wire

// File: rtl/result_monitor.sv
// ============================================================================
// Module   : result_monitor
// Purpose  : Decodes the multiplexer result stream: captures dice throws,
//            tracks the traffic-light sequence and flags errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_monitor #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    result_monitor_if.slave       mon_if,
    input  wire logic             err_clr_i,
    output logic [2:0]            dice_val_o,
    output logic                  dice_valid_o,
    output logic [2:0]            light_state_o,
    output logic                  locked_o,
    output logic [CNT_W-1:0]      cycles_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o
);

    // State encodings equal the light pattern they track.
    typedef enum logic [2:0] {
        UNSYNC  = 3'b000,
        S_RED   = 3'b100,
        S_RA    = 3'b110,
        S_GREEN = 3'b001,
        S_AMBER = 3'b010
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [1:0]       c_ERR_DICE  = 2'b01;
    localparam logic [1:0]       c_ERR_ORDER = 2'b10;
    localparam logic [1:0]       c_ERR_PATT  = 2'b11;

    state_t            state_q, state_d;
    logic [2:0]        dice_val_q, dice_val_d;
    logic              dice_valid_q, dice_valid_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    state_t            w_pat_state;
    state_t            w_next_state;
    logic              w_legal;
    logic              w_err_ev;
    logic [1:0]        w_err_ev_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= UNSYNC;
            dice_val_q   <= 3'd0;
            dice_valid_q <= 1'b0;
            cycles_q     <= '0;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            dice_val_q   <= dice_val_d;
            dice_valid_q <= dice_valid_d;
            cycles_q     <= cycles_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dice_val_d    = dice_val_q;
        dice_valid_d  = dice_valid_q;
        cycles_d      = cycles_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        w_err_ev      = 1'b0;
        w_err_ev_code = 2'b00;
        w_legal       = 1'b0;
        w_pat_state   = UNSYNC;
        w_next_state  = UNSYNC;

        case (mon_if.result)
            3'b100:  begin w_pat_state = S_RED;   w_legal = 1'b1; end
            3'b110:  begin w_pat_state = S_RA;    w_legal = 1'b1; end
            3'b001:  begin w_pat_state = S_GREEN; w_legal = 1'b1; end
            3'b010:  begin w_pat_state = S_AMBER; w_legal = 1'b1; end
            default: ;
        endcase

        case (state_q)
            S_RED:   w_next_state = S_RA;
            S_RA:    w_next_state = S_GREEN;
            S_GREEN: w_next_state = S_AMBER;
            S_AMBER: w_next_state = S_RED;
            default: w_next_state = UNSYNC;
        endcase

        if (!mon_if.sel) begin
            state_d = UNSYNC;
            if (mon_if.result != 3'd0 && mon_if.result != 3'd7) begin
                dice_val_d   = mon_if.result;
                dice_valid_d = 1'b1;
            end else begin
                w_err_ev      = 1'b1;
                w_err_ev_code = c_ERR_DICE;
            end
        end else if (state_q == UNSYNC) begin
            if (w_legal) begin
                state_d = w_pat_state;
            end else begin
                w_err_ev      = 1'b1;
                w_err_ev_code = c_ERR_PATT;
            end
        end else if (!w_legal) begin
            state_d       = UNSYNC;
            w_err_ev      = 1'b1;
            w_err_ev_code = c_ERR_PATT;
        end else if (w_pat_state == state_q) begin
            state_d = state_q;
        end else if (w_pat_state == w_next_state) begin
            state_d = w_next_state;
            if (state_q == S_AMBER && cycles_q != c_CNT_MAX) begin
                cycles_d = cycles_q + CNT_W'(1);
            end
        end else begin
            state_d       = UNSYNC;
            w_err_ev      = 1'b1;
            w_err_ev_code = c_ERR_ORDER;
        end

        // A fresh error event takes priority over a simultaneous clear.
        if (w_err_ev) begin
            error_d    = 1'b1;
            err_code_d = w_err_ev_code;
        end else if (err_clr_i) begin
            error_d    = 1'b0;
            err_code_d = 2'b00;
        end
    end

    assign dice_val_o    = dice_val_q;
    assign dice_valid_o  = dice_valid_q;
    assign light_state_o = state_q;
    assign locked_o      = (state_q != UNSYNC);
    assign cycles_o      = cycles_q;
    assign error_o       = error_q;
    assign err_code_o    = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_result_monitor.sv
// ============================================================================
// Module   : tb_result_monitor
// Purpose  : Self-checking bench for result_monitor (CNT_W=8 and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_clr = 1'b0;
    always #5 clk = ~clk;

    result_monitor_if bus ();

    logic [2:0] a_dice_val, b_dice_val, a_light, b_light;
    logic       a_dice_valid, b_dice_valid, a_locked, b_locked, a_error, b_error;
    logic [7:0] a_cycles;
    logic [1:0] b_cycles;
    logic [1:0] a_code, b_code;

    result_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .mon_if(bus), .err_clr_i(err_clr),
        .dice_val_o(a_dice_val), .dice_valid_o(a_dice_valid),
        .light_state_o(a_light), .locked_o(a_locked), .cycles_o(a_cycles),
        .error_o(a_error), .err_code_o(a_code));

    result_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .mon_if(bus), .err_clr_i(err_clr),
        .dice_val_o(b_dice_val), .dice_valid_o(b_dice_valid),
        .light_state_o(b_light), .locked_o(b_locked), .cycles_o(b_cycles),
        .error_o(b_error), .err_code_o(b_code));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: lights are a position in a 4-step ring.
    logic [2:0] ring [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    logic [2:0] m_dice_val;
    bit         m_dice_valid;
    bit         m_locked;
    int         m_pos;
    int         m_cycles;
    bit         m_error;
    logic [1:0] m_code;

    function automatic int ring_pos(input logic [2:0] p);
        for (int i = 0; i < 4; i++) if (ring[i] == p) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_dice_val = 3'd0; m_dice_valid = 0; m_locked = 0; m_pos = 0;
        m_cycles = 0; m_error = 0; m_code = 2'b00;
    endfunction

    function automatic void model_step(input bit s, input logic [2:0] r, input bit clr);
        int p;
        int ev;
        ev = 0;
        if (!s) begin
            m_locked = 0;
            if (r >= 1 && r <= 6) begin m_dice_val = r; m_dice_valid = 1; end
            else ev = 1;
        end else begin
            p = ring_pos(r);
            if (!m_locked) begin
                if (p < 0) ev = 3;
                else begin m_locked = 1; m_pos = p; end
            end else if (p < 0) begin
                m_locked = 0; ev = 3;
            end else if (p == (m_pos + 1) % 4) begin
                if (m_pos == 3) m_cycles++;
                m_pos = p;
            end else if (p != m_pos) begin
                m_locked = 0; ev = 2;
            end
        end
        if (ev != 0) begin m_error = 1; m_code = 2'(ev); end
        else if (clr) begin m_error = 0; m_code = 2'b00; end
    endfunction

    // {dice_val, dice_valid, light, locked, error, code, cycles8, cycles2} for both DUTs.
    function automatic logic [41:0] observed();
        return {a_dice_val, a_dice_valid, a_light, a_locked, a_error, a_code, a_cycles, 2'b00,
                b_dice_val, b_dice_valid, b_light, b_locked, b_error, b_code, 8'h00, b_cycles};
    endfunction

    function automatic logic [41:0] expected();
        logic [2:0] l;
        logic [7:0] c8;
        logic [1:0] c2;
        logic [20:0] one;
        l   = m_locked ? ring[m_pos] : 3'b000;
        c8  = (m_cycles > 255) ? 8'd255 : 8'(m_cycles);
        c2  = (m_cycles > 3) ? 2'd3 : 2'(m_cycles);
        one = {m_dice_val, m_dice_valid, l, m_locked, m_error, m_code, 8'h00, 2'b00};
        return {one[20:10], c8, 2'b00, one[20:10], 8'h00, c2};
    endfunction

    task automatic step(input bit s, input logic [2:0] r, input bit clr);
        bus.sel = s; bus.result = r; err_clr = clr;
        @(posedge clk);
        model_step(s, r, clr);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 3'b100, 0);
        step(1, 3'b110, 0);
        bus.sel = 1'b1; bus.result = 3'b110;
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (observed() !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0", observed());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 3'b110, 0);
        n_checks++;
        if (a_light !== 3'b110 || a_locked !== 1'b1 || a_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resync: light=%b locked=%b error=%b expected 110 1 0",
                     a_light, a_locked, a_error);
        end
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL reset_model: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_dice();
        logic [2:0] thr   [5] = '{3'd3, 3'd6, 3'd7, 3'd0, 3'd2};
        logic [2:0] exp_v [5] = '{3'd3, 3'd6, 3'd6, 3'd6, 3'd2};
        bit         exp_e [5] = '{0, 0, 1, 1, 1};
        for (int i = 0; i < 5; i++) begin
            step(0, thr[i], 0);
            n_checks++;
            if (a_dice_val !== exp_v[i] || a_dice_valid !== 1'b1 || a_error !== exp_e[i] ||
                (exp_e[i] && a_code !== 2'b01) || a_locked !== 1'b0) begin
                n_fail++;
                $display("FAIL dice[%0d]: val=%0d valid=%b err=%b code=%b expected val=%0d valid=1 err=%b",
                         i, a_dice_val, a_dice_valid, a_error, a_code, exp_v[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_full_cycle();
        logic [2:0] seq [12] = '{3'b100, 3'b100, 3'b100, 3'b110, 3'b110, 3'b001,
                                 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
        step(0, 3'd4, 1);
        for (int i = 0; i < 12; i++) begin
            step(1, seq[i], 0);
            n_checks++;
            if (a_locked !== 1'b1 || a_error !== 1'b0 || a_light !== seq[i] ||
                observed() !== expected()) begin
                n_fail++;
                $display("FAIL full_cycle[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (a_cycles !== 8'd1 || b_cycles !== 2'd1) begin
            n_fail++;
            $display("FAIL full_cycle_count: cycles=%0d/%0d expected 1", a_cycles, b_cycles);
        end
    endtask

    task automatic test_order_error();
        step(1, 3'b001, 0);
        n_checks++;
        if (a_locked !== 1'b0 || a_error !== 1'b1 || a_code !== 2'b10) begin
            n_fail++;
            $display("FAIL order_err: locked=%b error=%b code=%b expected 0 1 10",
                     a_locked, a_error, a_code);
        end
        step(1, 3'b001, 0);
        n_checks++;
        if (a_light !== 3'b001 || a_locked !== 1'b1 || a_code !== 2'b10 ||
            observed() !== expected()) begin
            n_fail++;
            $display("FAIL order_resync: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_illegal_clear();
        step(1, 3'b111, 0);
        n_checks++;
        if (a_code !== 2'b11 || a_locked !== 1'b0 || a_light !== 3'b000) begin
            n_fail++;
            $display("FAIL illegal: code=%b locked=%b expected 11 0", a_code, a_locked);
        end
        step(1, 3'b001, 1);
        n_checks++;
        if (a_error !== 1'b0 || a_code !== 2'b00 || observed() !== expected()) begin
            n_fail++;
            $display("FAIL err_clr: error=%b code=%b expected 0 00", a_error, a_code);
        end
        step(1, 3'b101, 1);
        n_checks++;
        if (a_error !== 1'b1 || a_code !== 2'b11 || b_code !== 2'b11) begin
            n_fail++;
            $display("FAIL clr_vs_err: error=%b code=%b expected 1 11", a_error, a_code);
        end
    endtask

    task automatic test_mode_switch_sat();
        int c8;
        step(1, 3'b100, 1);
        for (int k = 0; k < 4; k++) begin
            step(1, 3'b110, 0); step(1, 3'b001, 0); step(1, 3'b010, 0); step(1, 3'b100, 0);
        end
        n_checks++;
        if (b_cycles !== 2'd3 || b_error !== 1'b0 || observed() !== expected()) begin
            n_fail++;
            $display("FAIL saturate: cycles2=%0d cycles8=%0d expected 3 and %0d",
                     b_cycles, a_cycles, m_cycles);
        end
        c8 = int'(a_cycles);
        step(0, 3'd5, 0);
        n_checks++;
        if (a_locked !== 1'b0 || a_dice_val !== 3'd5) begin
            n_fail++;
            $display("FAIL sel_to_dice: locked=%b dice=%0d expected 0 5", a_locked, a_dice_val);
        end
        step(1, 3'b010, 0);
        n_checks++;
        if (a_locked !== 1'b1 || a_light !== 3'b010 || a_error !== 1'b0 ||
            int'(a_cycles) !== c8 || b_cycles !== 2'd3) begin
            n_fail++;
            $display("FAIL sel_to_lights: locked=%b light=%b error=%b cycles=%0d expected 1 010 0 %0d",
                     a_locked, a_light, a_error, a_cycles, c8);
        end
    endtask

    task automatic test_random();
        logic [2:0] r;
        bit s;
        int fails_here;
        fails_here = 0;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) != 0);
            if (s && m_locked && $urandom_range(0, 3) != 0)
                r = ($urandom_range(0, 1) != 0) ? ring[(m_pos + 1) % 4] : ring[m_pos];
            else
                r = 3'($urandom_range(0, 7));
            step(s, r, ($urandom_range(0, 7) == 0));
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                if (fails_here < 10)
                    $display("FAIL random[%0d]: sel=%b res=%b got %h expected %h",
                             i, s, r, observed(), expected());
                fails_here++;
            end
        end
    endtask

    initial begin
        bus.sel = 1'b1; bus.result = 3'b000;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (observed() !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected 0", observed());
        end
        test_reset();
        test_dice();
        test_full_cycle();
        test_order_error();
        test_illegal_clear();
        test_mode_switch_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
